// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: per-opcode FETCH/DECODE/EXEC/MEM/WB path with a
// mem_ready handshake, stall timeout, and sticky illegal/memory-error flags.
module mc_ctrl_fsm #(
   parameter int unsigned           ALUCTL_W = 3,
   parameter logic [ALUCTL_W-1:0]   ALU_ADD  = ALUCTL_W'(1),
   parameter logic [ALUCTL_W-1:0]   ALU_OR   = ALUCTL_W'(4),
   parameter logic [ALUCTL_W-1:0]   ALU_LUI  = ALUCTL_W'(0),
   parameter logic [ALUCTL_W-1:0]   ALU_NOP  = ALUCTL_W'(7),
   parameter int unsigned           TIMEOUT  = 16,
   parameter int unsigned           TO_W     = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic [5:0]          funct,
   input  logic                mem_ready,
   input  logic                err_clr,
   output logic [2:0]          curr_state,
   output logic                pc_write,
   output logic                ir_write,
   output logic                IorD,
   output logic                mem_read,
   output logic                MemWrite,
   output logic                RegDst,
   output logic                ALUSrc,
   output logic                MemtoReg,
   output logic                RegWrite,
   output logic [ALUCTL_W-1:0] ALUControl,
   output logic                Branch,
   output logic                j_en,
   output logic                bgtz_en,
   output logic                instr_done,
   output logic                illegal,
   output logic                mem_err
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_OR    = 6'b100101;

   state_t              state, state_d;
   logic [5:0]          op_q, fn_q;
   logic [TO_W-1:0]     to_cnt, to_cnt_d;
   logic                illegal_set, mem_err_set;
   logic                dec_legal, stall_to, waiting;
   logic                is_r, is_lw, is_sw;
   logic                ex_alusrc;
   logic [ALUCTL_W-1:0] ex_aluctl;

   assign curr_state = state;
   assign is_r  = (op_q == OP_RTYPE);
   assign is_lw = (op_q == OP_LW);
   assign is_sw = (op_q == OP_SW);

   // Legality is judged on the live IR fields, since op_q/fn_q are loaded in this same cycle.
   always_comb begin
      dec_legal = 1'b0;
      case (opcode)
         OP_RTYPE: dec_legal = (funct == FN_ADD) || (funct == FN_OR);
         OP_ADDI, OP_LW, OP_SW, OP_BGTZ, OP_J, OP_LUI, OP_ORI: dec_legal = 1'b1;
         default:  dec_legal = 1'b0;
      endcase
   end

   // EXEC-phase ALU setup; WB reuses it so the ALU result stays stable for the write.
   always_comb begin
      ex_alusrc = 1'b0;
      ex_aluctl = ALU_NOP;
      case (op_q)
         OP_RTYPE: ex_aluctl = (fn_q == FN_OR) ? ALU_OR : ALU_ADD;
         OP_ADDI, OP_LW, OP_SW: begin
            ex_alusrc = 1'b1;
            ex_aluctl = ALU_ADD;
         end
         OP_BGTZ:  ex_aluctl = ALU_ADD;
         OP_ORI: begin
            ex_alusrc = 1'b1;
            ex_aluctl = ALU_OR;
         end
         OP_LUI: begin
            ex_alusrc = 1'b1;
            ex_aluctl = ALU_LUI;
         end
         default:  ex_aluctl = ALU_NOP;
      endcase
   end

   assign waiting  = ((state == FETCH) || (state == MEM)) && !mem_ready;
   assign stall_to = waiting && (to_cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      IorD        = 1'b0;
      mem_read    = 1'b0;
      MemWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrc      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUControl  = ALU_NOP;
      Branch      = 1'b0;
      j_en        = 1'b0;
      bgtz_en     = 1'b0;
      instr_done  = 1'b0;
      illegal_set = 1'b0;
      mem_err_set = 1'b0;
      case (state)
         FETCH: begin
            mem_read   = 1'b1;
            ALUControl = ALU_ADD;
            pc_write   = mem_ready;
            ir_write   = mem_ready;
            if (stall_to) begin
               mem_err_set = 1'b1;
               state_d     = FETCH;
            end else if (mem_ready) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            if (!dec_legal) begin
               illegal_set = 1'b1;
               state_d     = FETCH;
            end else begin
               state_d = EXEC;
            end
         end
         EXEC: begin
            RegDst     = is_r;
            ALUSrc     = ex_alusrc;
            ALUControl = ex_aluctl;
            if (op_q == OP_BGTZ) begin
               Branch     = 1'b1;
               bgtz_en    = 1'b1;
               instr_done = 1'b1;
               state_d    = FETCH;
            end else if (op_q == OP_J) begin
               Branch     = 1'b1;
               j_en       = 1'b1;
               instr_done = 1'b1;
               state_d    = FETCH;
            end else if (is_lw || is_sw) begin
               state_d = MEM;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            IorD       = 1'b1;
            ALUSrc     = 1'b1;
            ALUControl = ALU_ADD;
            mem_read   = is_lw;
            MemWrite   = is_sw;
            if (stall_to) begin
               mem_err_set = 1'b1;
               state_d     = FETCH;
            end else if (mem_ready) begin
               if (is_lw) begin
                  state_d = WB;
               end else begin
                  instr_done = 1'b1;
                  state_d    = FETCH;
               end
            end
         end
         WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
            MemtoReg   = is_lw;
            RegDst     = is_r;
            ALUSrc     = ex_alusrc;
            ALUControl = ex_aluctl;
            state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Count only while lingering in FETCH/MEM without a ready; any entry or ready restarts it.
   assign to_cnt_d = (waiting && !stall_to && (state_d == state)) ? to_cnt + 1'b1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         op_q    <= '0;
         fn_q    <= '0;
         to_cnt  <= '0;
         illegal <= 1'b0;
         mem_err <= 1'b0;
      end else begin
         state  <= state_d;
         to_cnt <= to_cnt_d;
         if (state == DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
         end
         illegal <= illegal_set ? 1'b1 : (err_clr ? 1'b0 : illegal);
         mem_err <= mem_err_set ? 1'b1 : (err_clr ? 1'b0 : mem_err);
      end
   end

endmodule
